// File: rtl/param_seq_counter_pkg.sv
// Shared defaults and direction encoding for the modulo-N sequence counter slice.
package param_seq_counter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_MOD   = 10;
  localparam int DEF_OUT_W = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/param_seq_counter_if.sv
// Control/status bundle between a counter controller (master) and the counter (slave).
interface param_seq_counter_if
  import param_seq_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OUT_W = DEF_OUT_W
);

  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadVal;
  logic [WIDTH-1:0] Count;
  logic [OUT_W-1:0] Next;
  logic             Tc;
  logic             Wrapped;

  modport master (
    output En, Up, Load, LoadVal,
    input  Count, Next, Tc, Wrapped
  );

  modport slave (
    input  En, Up, Load, LoadVal,
    output Count, Next, Tc, Wrapped
  );

endinterface

// File: rtl/param_seq_counter_seq_lut.sv
// Combinational digit table: maps a count index to its programmed OUT_W-bit entry.
// Out-of-range indices (Count >= MOD) select entry 0.
module seq_lut
  import param_seq_counter_pkg::*;
#(
  parameter int                   WIDTH    = DEF_WIDTH,
  parameter int                   MOD      = DEF_MOD,
  parameter int                   OUT_W    = DEF_OUT_W,
  parameter logic [MOD*OUT_W-1:0] SEQ_INIT = '0
) (
  input  logic [WIDTH-1:0] Count,
  output logic [OUT_W-1:0] Next
);

  always_comb begin
    Next = SEQ_INIT[0 +: OUT_W];
    for (int unsigned i = 1; i < MOD; i++) begin
      if (Count == WIDTH'(i)) Next = SEQ_INIT[i*OUT_W +: OUT_W];
    end
  end

endmodule

// File: rtl/param_seq_counter.sv
// Parametrised modulo-MOD up/down counter with load, enable, terminal count and wrap pulse.
// Define SEQ_COUNTER_LUT_EN to map Count through the SEQ_INIT digit table on Next.
module param_seq_counter
  import param_seq_counter_pkg::*;
#(
  parameter int                   WIDTH    = DEF_WIDTH,
  parameter int                   MOD      = DEF_MOD,
  parameter int                   OUT_W    = DEF_OUT_W,
  parameter logic [MOD*OUT_W-1:0] SEQ_INIT = '0
) (
  input  logic                Clk,
  input  logic                Clr,
  param_seq_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_q;
  logic             at_top;
  logic             at_bottom;
  logic             tc;
  dir_e             dir;

  assign dir = bus.Up ? DIR_UP : DIR_DOWN;

  // Illegal states above MAX are folded into the wrap conditions of both directions.
  always_comb begin
    at_top    = (count_q >= MAX);
    at_bottom = (count_q == '0) || (count_q > MAX);
    tc        = bus.En && !bus.Load && ((dir == DIR_UP) ? at_top : at_bottom);
  end

  always_comb begin
    count_d = count_q;
    if (bus.Load) begin
      count_d = (bus.LoadVal > MAX) ? MAX : bus.LoadVal;
    end else if (bus.En) begin
      if (dir == DIR_UP) count_d = at_top    ? '0  : count_q + WIDTH'(1);
      else               count_d = at_bottom ? MAX : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= tc;
    end
  end

  assign bus.Count   = count_q;
  assign bus.Tc      = tc;
  assign bus.Wrapped = wrapped_q;

`ifdef SEQ_COUNTER_LUT_EN
  seq_lut #(
    .WIDTH    (WIDTH),
    .MOD      (MOD),
    .OUT_W    (OUT_W),
    .SEQ_INIT (SEQ_INIT)
  ) u_lut (
    .Count (count_q),
    .Next  (bus.Next)
  );
`else
  assign bus.Next = OUT_W'(count_q);
`endif

endmodule
